// File: rtl/hour_set_loader.sv
// hour_set_loader: captures a BCD hour (h2:h1), range-checks it against
// MAX_HOUR, converts it to binary by repeated +10 and offers the result to
// the hour counter with a valid/ack handshake.
module hour_set_loader #(
   parameter int MAX_HOUR = 23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] h2,
   input  logic [3:0] h1,
   input  logic       load_ack,
   output logic       load_valid,
   output logic [7:0] load_value,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, CHECK, CONVERT, OFFER, ERROR} state_t;

   state_t     state_q, state_n;
   logic [3:0] h2_q, h2_n, h1_q, h1_n;
   logic [7:0] acc_q, acc_n;
   logic [3:0] cnt_q, cnt_n;
   logic       lv_n, busy_n, err_n;
   logic [7:0] lval_n;
   logic [7:0] hour_sum;
   logic       digits_ok;

   // Range check on the captured digits; 15*10+15 still fits in 8 bits.
   always_comb begin
      hour_sum  = 8'(h2_q) * 8'd10 + 8'(h1_q);
      digits_ok = (h2_q <= 4'd9) && (h1_q <= 4'd9) && (int'(hour_sum) <= MAX_HOUR);
   end

   // Next-state and next-output decode; every register defaults to hold.
   always_comb begin
      state_n = state_q;
      h2_n    = h2_q;
      h1_n    = h1_q;
      acc_n   = acc_q;
      cnt_n   = cnt_q;
      lv_n    = load_valid;
      lval_n  = load_value;
      err_n   = err;
      case (state_q)
         IDLE: begin
            if (start) begin
               h2_n    = h2;
               h1_n    = h1;
               err_n   = 1'b0;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (abort) begin
               state_n = IDLE;
            end else if (digits_ok) begin
               acc_n   = 8'(h1_q);
               cnt_n   = h2_q;
               state_n = CONVERT;
            end else begin
               err_n   = 1'b1;
               state_n = ERROR;
            end
         end
         CONVERT: begin
            if (abort) begin
               state_n = IDLE;
            end else if (cnt_q != 4'd0) begin
               acc_n = acc_q + 8'd10;
               cnt_n = cnt_q - 4'd1;
            end else begin
               lval_n  = acc_q;
               lv_n    = 1'b1;
               state_n = OFFER;
            end
         end
         OFFER: begin
            // ack and abort both end the offer; with both set the transfer
            // is considered delivered, which looks the same at the outputs.
            if (load_ack || abort) begin
               lv_n    = 1'b0;
               state_n = IDLE;
            end
         end
         ERROR: begin
            state_n = IDLE;
         end
         default: begin
            lv_n    = 1'b0;
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         h2_q       <= '0;
         h1_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         load_valid <= 1'b0;
         load_value <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_n;
         h2_q       <= h2_n;
         h1_q       <= h1_n;
         acc_q      <= acc_n;
         cnt_q      <= cnt_n;
         load_valid <= lv_n;
         load_value <= lval_n;
         busy       <= busy_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_hour_set_loader.sv
// Directed bench for hour_set_loader: expected hours go to a scoreboard
// queue at start time and are popped when load_valid shows up.
module tb_hour_set_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] h2 = '0;
   logic [3:0] h1 = '0;
   logic       load_ack = 1'b0;
   logic       load_valid;
   logic [7:0] load_value;
   logic       busy;
   logic       err;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   hour_set_loader #(.MAX_HOUR(23)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .h2(h2), .h1(h1), .load_ack(load_ack),
      .load_valid(load_valid), .load_value(load_value),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse start with the given digits (edge E0), then scramble the inputs.
   task automatic kick(input logic [3:0] d2, input logic [3:0] d1);
      h2 = d2; h1 = d1; start = 1'b1;
      tick();
      start = 1'b0;
      h2 = 4'd9; h1 = 4'd9;
   endtask

   // Valid request: run to OFFER, check latency 2+h2 and the offered value.
   task automatic offer(input string tag, input logic [3:0] d2, input logic [3:0] d1);
      int n;
      logic [7:0] e;
      exp_q.push_back(8'(d2) * 8'd10 + 8'(d1));
      kick(d2, d1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      n = 0;
      while (!load_valid && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(2 + int'(d2)));
      if (load_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_val"}, 32'(load_value), 32'(e));
      end
   endtask

   task automatic ack_it(input string tag, input logic [7:0] held);
      load_ack = 1'b1;
      tick();
      load_ack = 1'b0;
      chk({tag, "_ack_lv"}, 32'(load_valid), 32'd0);
      chk({tag, "_ack_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ack_hold"}, 32'(load_value), 32'(held));
   endtask

   // Out-of-range request: err after E1, idle after E2, never offered.
   task automatic reject(input string tag, input logic [3:0] d2, input logic [3:0] d1);
      kick(d2, d1);
      tick();
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_busy1"}, 32'(busy), 32'd1);
      tick();
      chk({tag, "_busy2"}, 32'(busy), 32'd0);
      chk({tag, "_lv"}, 32'(load_valid), 32'd0);
   endtask

   initial begin
      // Asynchronous reset, checked before any clock edge
      #1 reset = 1'b0;
      #1;
      chk("rst_lv", 32'(load_valid), 32'd0);
      chk("rst_val", 32'(load_value), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      reset = 1'b1;

      // 17: latency E3, then ack; inputs changed after E0 must not matter
      offer("h17", 4'd1, 4'd7);
      ack_it("h17", 8'd17);
      chk("h17_err", 32'(err), 32'd0);

      // 24 rejected, then 5 clears err at acceptance
      reject("h24", 4'd2, 4'd4);
      h2 = 4'd0; h1 = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("h05_errclr", 32'(err), 32'd0);
      tick();
      tick();
      chk("h05_lv", 32'(load_valid), 32'd1);
      chk("h05_val", 32'(load_value), 32'd5);
      if (exp_q.size() == 0) exp_q.push_back(8'd5);
      void'(exp_q.pop_front());
      ack_it("h05", 8'd5);

      // 00 held in OFFER for 6 cycles with stray start pulses
      offer("h00", 4'd0, 4'd0);
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         h2 = 4'd1; h1 = 4'd1;
         tick();
         chk("h00_hold_lv", 32'(load_valid), 32'd1);
         chk("h00_hold_val", 32'(load_value), 32'd0);
      end
      start = 1'b0;
      ack_it("h00", 8'd0);
      tick();
      tick();
      chk("h00_nostray", 32'(busy), 32'd0);

      // Boundaries and bad digits
      offer("h23", 4'd2, 4'd3);
      ack_it("h23", 8'd23);
      offer("h09", 4'd0, 4'd9);
      ack_it("h09", 8'd9);
      offer("h10", 4'd1, 4'd0);
      ack_it("h10", 8'd10);
      reject("h1A", 4'd1, 4'hA);
      reject("hF0", 4'hF, 4'd0);

      // ack outside OFFER is ignored
      load_ack = 1'b1;
      tick();
      load_ack = 1'b0;
      chk("stray_ack_err", 32'(err), 32'd1);

      // abort in ERROR keeps err
      kick(4'd3, 4'd0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_err_busy", 32'(busy), 32'd0);
      chk("abort_err_err", 32'(err), 32'd1);

      // abort in CONVERT at E3 for h2=2
      kick(4'd2, 4'd1);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_cnv_busy", 32'(busy), 32'd0);
      chk("abort_cnv_lv", 32'(load_valid), 32'd0);
      chk("abort_cnv_err", 32'(err), 32'd0);
      tick();
      tick();
      chk("abort_cnv_none", 32'(load_valid), 32'd0);

      // abort + ack together in OFFER: transfer completes
      offer("h12", 4'd1, 4'd2);
      abort = 1'b1;
      ack_it("h12", 8'd12);
      abort = 1'b0;

      // abort alone in OFFER
      offer("h20", 4'd2, 4'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_off_lv", 32'(load_valid), 32'd0);
      chk("abort_off_busy", 32'(busy), 32'd0);

      // reset between edges while offering
      offer("h15", 4'd1, 4'd5);
      #2 reset = 1'b0;
      #1;
      chk("rst_off_lv", 32'(load_valid), 32'd0);
      chk("rst_off_busy", 32'(busy), 32'd0);
      chk("rst_off_val", 32'(load_value), 32'd0);
      tick();
      tick();
      chk("rst_held_lv", 32'(load_valid), 32'd0);
      reset = 1'b1;
      tick();
      tick();
      chk("rst_rel_lv", 32'(load_valid), 32'd0);
      chk("rst_rel_busy", 32'(busy), 32'd0);

      // first start after release is accepted at the first edge
      #2 reset = 1'b0;
      #1 reset = 1'b1;
      offer("h21", 4'd2, 4'd1);
      ack_it("h21", 8'd21);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
